bus_cycle_sequencer: RTL

- Timing master directly upstream of the data controller.
- Divides clk32 time into 4-clk8 memory slots shared between video and CPU.
- Produces the bus-ownership, latch, pixel-load and sound-load strobes, and the 68000 E clock edge pulses.
- Runs the VPA→VMA handshake for 6800-style peripherals (VIA) and DTACK for RAM/ROM cycles.

---
 rtl/bus_cycle_sequencer_if.sv | 34 +++
 rtl/bus_cycle_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer_if.sv
// Bus-side signal bundle for bus_cycle_sequencer.
//   master : the sequencer (drives ownership/strobes/E pulses/VMA/DTACK)
//   slave  : CPU, video and sound side (drives AS, VPA, selectMem, blanking)
// Signal names keep the 68000/Mac board naming used on the schematic.
interface bus_cycle_sequencer_if;
  // CPU / video inputs to the sequencer
  logic _cpuAS;
  logic _cpuVPA;
  logic selectMem;
  logic _hblank;
  logic _vblank;
  // sequencer outputs
  logic videoBusControl;
  logic cpuBusControl;
  logic memoryLatch;
  logic loadPixels;
  logic loadSound;
  logic E_rising;
  logic E_falling;
  logic _cpuVMA;
  logic _cpuDTACK;

  modport master (
    input  _cpuAS, _cpuVPA, selectMem, _hblank, _vblank,
    output videoBusControl, cpuBusControl, memoryLatch, loadPixels, loadSound,
           E_rising, E_falling, _cpuVMA, _cpuDTACK
  );

  modport slave (
    output _cpuAS, _cpuVPA, selectMem, _hblank, _vblank,
    input  videoBusControl, cpuBusControl, memoryLatch, loadPixels, loadSound,
           E_rising, E_falling, _cpuVMA, _cpuDTACK
  );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: memory slot timing master.
// Splits clk32 time into 4-beat clk8 slots alternating video/CPU, emits the
// memory latch, pixel and sound load strobes, generates 68000 E clock edge
// pulses, runs the VPA->VMA handshake for 6800-style peripherals and DTACK
// for RAM/ROM accesses.
//
// Ports:
//   clk32        system clock
//   _systemReset asynchronous active-low reset
//   clk8_en_p    clk8 positive-phase enable (one clk32 wide)
//   clk8_en_n    clk8 negative-phase enable (one clk32 wide)
//   bus          bus_cycle_sequencer_if.master (CPU strobes, blanking,
//                ownership, strobes, E pulses, _cpuVMA, _cpuDTACK)
//
// Parameters:
//   E_DIV   E clock period in clk8 beats
//   E_HIGH  E high time in clk8 beats (< E_DIV)
//
// Build option: define CPU_BLANK_SLOTS_EN to hand video slots to the CPU
// during blanking when no sound fetch is pending. Default build is strict
// video/CPU alternation.
module bus_cycle_sequencer #(
  parameter int E_DIV  = 10,
  parameter int E_HIGH = 4
) (
  input  logic                         clk32,
  input  logic                         _systemReset,
  input  logic                         clk8_en_p,
  input  logic                         clk8_en_n,
  bus_cycle_sequencer_if.master        bus
);

  localparam int EW = (E_DIV > 1) ? $clog2(E_DIV) : 1;
  localparam logic [EW-1:0] E_LAST     = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_RISE_CNT = EW'(E_DIV - E_HIGH);

  typedef enum logic [1:0] {
    VMA_IDLE  = 2'd0,
    VMA_SYNC  = 2'd1,
    VMA_CYCLE = 2'd2,
    VMA_DONE  = 2'd3
  } vma_state_t;

  // ---------------------------------------------------------------------
  // Slot state
  // ---------------------------------------------------------------------
  logic [1:0]    phase;
  logic          owner_cpu;      // strict alternation: 0 = video slot
  logic          video_q;
  logic          cpu_q;
  logic          slot_end;
  logic          grant_cpu_next;
  logic          latch_hit;

  // Sound fetch tracking
  logic          hblank_prev;
  logic          hblank_fall;
  logic          sound_pending;
  logic          sound_fire;

  // Strobe registers
  logic          mem_latch_q;
  logic          load_pix_q;
  logic          load_snd_q;

  // E clock
  logic [EW-1:0] e_cnt;
  logic [EW-1:0] e_next;
  logic          e_rise_q;
  logic          e_fall_q;

  // VMA handshake
  vma_state_t    vma_state, vma_state_n;
  logic          vma_n_q;
  logic          vma_n_next;

  // DTACK
  logic          mem_req;
  logic          dtack_armed;
  logic          dtack_n_q;

  assign slot_end    = clk8_en_p && (phase == 2'd3);
  assign latch_hit   = clk8_en_n && (phase == 2'd2);
  assign hblank_fall = clk8_en_p && hblank_prev && !bus._hblank;
  assign sound_fire  = latch_hit && video_q && sound_pending;

  // Who gets the slot that starts at the next phase 3->0 wrap.
`ifdef CPU_BLANK_SLOTS_EN
  // During blanking a video slot is only needed for a sound fetch; the
  // same-edge hblank fall counts as pending so that fetch is not lost.
  assign grant_cpu_next = !owner_cpu ||
                          ((!bus._hblank || !bus._vblank) &&
                           !(sound_pending || hblank_fall));
`else
  assign grant_cpu_next = !owner_cpu;
`endif

  // ---------------------------------------------------------------------
  // Slot counter and ownership
  // ---------------------------------------------------------------------
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      phase     <= 2'd0;
      owner_cpu <= 1'b0;
      video_q   <= 1'b1;
      cpu_q     <= 1'b0;
    end else if (clk8_en_p) begin
      phase <= phase + 2'd1;
      if (phase == 2'd3) begin
        owner_cpu <= !owner_cpu;
        cpu_q     <= grant_cpu_next;
        video_q   <= !grant_cpu_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Latch / pixel / sound strobes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      mem_latch_q   <= 1'b0;
      load_pix_q    <= 1'b0;
      load_snd_q    <= 1'b0;
      hblank_prev   <= 1'b0;   // no fall is seen until hblank is first high
      sound_pending <= 1'b0;
    end else begin
      mem_latch_q <= latch_hit;
      load_pix_q  <= latch_hit && video_q && bus._hblank && bus._vblank;
      load_snd_q  <= sound_fire;
      if (clk8_en_p)
        hblank_prev <= bus._hblank;
      // A second fall while still pending is simply absorbed.
      if (sound_fire)
        sound_pending <= 1'b0;
      else if (hblank_fall)
        sound_pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // E clock edge pulses
  // ---------------------------------------------------------------------
  assign e_next = (e_cnt == E_LAST) ? '0 : e_cnt + 1'b1;

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      e_cnt    <= '0;
      e_rise_q <= 1'b0;
      e_fall_q <= 1'b0;
    end else begin
      e_rise_q <= clk8_en_p && (e_next == E_RISE_CNT);
      e_fall_q <= clk8_en_p && (e_next == '0);
      if (clk8_en_p)
        e_cnt <= e_next;
    end
  end

  // ---------------------------------------------------------------------
  // VPA -> VMA handshake
  // ---------------------------------------------------------------------
  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      vma_state <= VMA_IDLE;
      vma_n_q   <= 1'b1;
    end else begin
      vma_state <= vma_state_n;
      vma_n_q   <= vma_n_next;
    end
  end

  always_comb begin
    vma_state_n = vma_state;
    vma_n_next  = 1'b1;
    case (vma_state)
      VMA_IDLE:  if (!bus._cpuAS && !bus._cpuVPA) vma_state_n = VMA_SYNC;
      VMA_SYNC:  if (e_fall_q) vma_state_n = VMA_CYCLE;
      VMA_CYCLE: if (e_fall_q) vma_state_n = VMA_DONE;   // VIA transfer edge
      VMA_DONE:  vma_state_n = VMA_DONE;
      default:   vma_state_n = VMA_IDLE;
    endcase
    // AS negated ends (or aborts) the cycle from any state.
    if (bus._cpuAS)
      vma_state_n = VMA_IDLE;
    vma_n_next = !((vma_state_n == VMA_CYCLE) || (vma_state_n == VMA_DONE));
  end

  // ---------------------------------------------------------------------
  // DTACK for RAM/ROM
  // ---------------------------------------------------------------------
  assign mem_req = !bus._cpuAS && bus._cpuVPA && bus.selectMem;

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      dtack_armed <= 1'b0;
      dtack_n_q   <= 1'b1;
    end else begin
      // Only a request already present when a CPU slot starts may use it;
      // one that shows up mid-slot waits for the next CPU slot.
      if (slot_end)
        dtack_armed <= mem_req && grant_cpu_next;
      else if (!mem_req)
        dtack_armed <= 1'b0;

      if (bus._cpuAS)
        dtack_n_q <= 1'b1;
      else if (mem_latch_q && cpu_q && dtack_armed && mem_req)
        dtack_n_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.videoBusControl = video_q;
  assign bus.cpuBusControl   = cpu_q;
  assign bus.memoryLatch     = mem_latch_q;
  assign bus.loadPixels      = load_pix_q;
  assign bus.loadSound       = load_snd_q;
  assign bus.E_rising        = e_rise_q;
  assign bus.E_falling       = e_fall_q;
  assign bus._cpuVMA         = vma_n_q;
  assign bus._cpuDTACK       = dtack_n_q;

endmodule
